// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: 640x480@60 Hz constants, derived totals and
// the coordinate type used by the sync generator and the object renderers.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive range test used for the sync pulse decode.
    function automatic logic in_span(coord_t pos, coord_t lo, coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Scan position and sync/blank bundle published by vga_sync_gen.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   pixel_tick;
    coord_t HCount;
    coord_t VCount;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_start;

    modport master (
        output pixel_tick, HCount, VCount, hsync, vsync, video_on, frame_start
    );

    modport slave (
        input pixel_tick, HCount, VCount, hsync, vsync, video_on, frame_start
    );

endinterface

// File: rtl/vga_pixel_div.sv
// Board-clock to pixel divider. adv_o is the combinational "advance this
// edge" strobe for the scan counters; pixel_tick_o is its registered copy,
// so it rises on the same edge the counters move.
module vga_pixel_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic adv_o,
    output logic pixel_tick_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;

    // Next divider value: wrap after the last board clock of a pixel.
    always_comb begin
        adv_o = (div_q == DIV_LAST);
        div_d = adv_o ? '0 : div_q + DIV_W'(1);
    end

    // Divider state and registered tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= adv_o;
        end
    end

    assign pixel_tick_o = tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan/sync generator: pixel divider, H/V scan counters, active-low
// hsync/vsync, video_on blanking and a frame_start pulse.
// Optional macro VGA_SYNC_PIPE_EN adds a pixel-tick-enabled register stage on
// hsync/vsync/video_on so they lag the counters by one pixel.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST = COORD_W'(H_TOTAL - 1);
    localparam coord_t V_LAST = COORD_W'(V_TOTAL - 1);
    localparam coord_t H_VIS  = COORD_W'(H_DISPLAY);
    localparam coord_t V_VIS  = COORD_W'(V_DISPLAY);
    localparam coord_t HS_LO  = COORD_W'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_HI  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO  = COORD_W'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_HI  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   adv;
    logic   pixel_tick;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   video_q, video_d;
    logic   frame_q, frame_d;

    vga_pixel_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk          (clk),
        .rst_n        (rst_n),
        .adv_o        (adv),
        .pixel_tick_o (pixel_tick)
    );

    // Next scan position and the sync/blank decode of that position, so the
    // registered outputs always match the counters shown in the same cycle.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = 1'b0;
        if (adv) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d     = '0;
                    frame_d = 1'b1;
                end else begin
                    v_d = v_q + COORD_W'(1);
                end
            end else begin
                h_d = h_q + COORD_W'(1);
            end
        end
        hsync_d = !in_span(h_d, HS_LO, HS_HI);
        vsync_d = !in_span(v_d, VS_LO, VS_HI);
        video_d = (h_d < H_VIS) && (v_d < V_VIS);
    end

    // Scan counters and registered sync/blank/frame outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            frame_q <= frame_d;
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    logic hsync_p_q;
    logic vsync_p_q;
    logic video_p_q;

    // One-pixel delay stage for alignment with a registered RGB mux.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_p_q <= 1'b1;
            vsync_p_q <= 1'b1;
            video_p_q <= 1'b0;
        end else if (adv) begin
            hsync_p_q <= hsync_q;
            vsync_p_q <= vsync_q;
            video_p_q <= video_q;
        end
    end

    assign vga.hsync    = hsync_p_q;
    assign vga.vsync    = vsync_p_q;
    assign vga.video_on = video_p_q;
`else
    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.video_on = video_q;
`endif

    assign vga.pixel_tick  = pixel_tick;
    assign vga.HCount      = h_q;
    assign vga.VCount      = v_q;
    assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default-timing instance (A) for line
// timing, and two shrunken-timing instances (B: CLK_DIV=3, C: CLK_DIV=1) so
// whole frames fit in a short run.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

`ifdef VGA_SYNC_PIPE_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #10 clk = ~clk;

    // Clocks since the last reset release; sampled at negedge it equals the
    // number of post-release edges.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    vga_sync_gen dut_a (.clk(clk), .rst_n(rst_n), .vga(if_a));

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_b (.clk(clk), .rst_n(rst_n), .vga(if_b));

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_c (.clk(clk), .rst_n(rst_n), .vga(if_c));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({if_a.HCount, if_a.VCount, if_a.hsync, if_a.vsync, if_a.video_on,
                 if_a.pixel_tick, if_a.frame_start} !==
                {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_a: got H=%0d V=%0d hs=%b vs=%b vo=%b tick=%b fs=%b, expected 0 0 1 1 0 0 0",
                         if_a.HCount, if_a.VCount, if_a.hsync, if_a.vsync,
                         if_a.video_on, if_a.pixel_tick, if_a.frame_start);
            end
            checks++;
            if ({if_b.HCount, if_b.VCount, if_b.hsync, if_b.vsync, if_b.video_on,
                 if_b.frame_start} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_b: got H=%0d V=%0d hs=%b vs=%b vo=%b fs=%b, expected 0 0 1 1 0 0",
                         if_b.HCount, if_b.VCount, if_b.hsync, if_b.vsync,
                         if_b.video_on, if_b.frame_start);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({if_a.HCount, if_a.VCount, if_a.pixel_tick} !== {10'd0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL release_pos: got H=%0d V=%0d tick=%b, expected 0 0 0",
                     if_a.HCount, if_a.VCount, if_a.pixel_tick);
        end
        checks++;
        if (if_a.video_on !== 1'(LAG == 0)) begin
            errors++;
            $display("FAIL release_video_on: got %b, expected %b", if_a.video_on, 1'(LAG == 0));
        end
    endtask

    // Tick cadence on A (CLK_DIV=2) and C (CLK_DIV=1), C position, and no
    // frame_start anywhere shortly after release.
    task automatic test_div();
        int bad_a_tick = 0, bad_c_tick = 0, bad_c_pos = 0, bad_fs = 0;
        for (int i = 0; i < 30; i++) begin
            if (if_a.pixel_tick !== 1'((cyc % 2) == 0)) bad_a_tick++;
            if (if_c.pixel_tick !== 1'b1) bad_c_tick++;
            if (if_c.HCount !== 10'(cyc % 15) || if_c.VCount !== 10'((cyc / 15) % 10)) bad_c_pos++;
            if ({if_a.frame_start, if_b.frame_start, if_c.frame_start} !== 3'b000) bad_fs++;
            step();
        end
        checks++;
        if (bad_a_tick != 0) begin
            errors++;
            $display("FAIL tick_div2: %0d bad cycles, expected 0", bad_a_tick);
        end
        checks++;
        if (bad_c_tick != 0) begin
            errors++;
            $display("FAIL tick_div1: %0d cycles with tick low, expected 0", bad_c_tick);
        end
        checks++;
        if (bad_c_pos != 0) begin
            errors++;
            $display("FAIL pos_div1: %0d bad positions, expected 0", bad_c_pos);
        end
        checks++;
        if (bad_fs != 0) begin
            errors++;
            $display("FAIL no_frame_start: %0d cycles with frame_start, expected 0", bad_fs);
        end
    endtask

    // Two lines of instance A: wraps, hsync window and video_on edges.
    task automatic test_line();
        int wrap1 = -1, wrap2 = -1, wrap1_v = -1, wrap2_v = -1;
        int hs_fall_cyc = -1, hs_fall_h = -1, hs_low = 0;
        int vo_fall_h = -1, vo_rise_h = -1;
        logic [9:0] ph = if_a.HCount;
        logic phs = if_a.hsync;
        logic pvo = if_a.video_on;
        while (cyc < 3300) begin
            step();
            if (ph == 10'd799 && if_a.HCount == 10'd0) begin
                if (wrap1 < 0) begin wrap1 = cyc; wrap1_v = int'(if_a.VCount); end
                else if (wrap2 < 0) begin wrap2 = cyc; wrap2_v = int'(if_a.VCount); end
            end
            if (phs && !if_a.hsync && hs_fall_cyc < 0) begin
                hs_fall_cyc = cyc;
                hs_fall_h   = int'(if_a.HCount);
            end
            if (!if_a.hsync && cyc < 1600) hs_low++;
            if (pvo && !if_a.video_on && vo_fall_h < 0) vo_fall_h = int'(if_a.HCount);
            if (!pvo && if_a.video_on && vo_fall_h >= 0 && vo_rise_h < 0) vo_rise_h = int'(if_a.HCount);
            ph  = if_a.HCount;
            phs = if_a.hsync;
            pvo = if_a.video_on;
        end
        checks++;
        if (wrap1 != 1600 || wrap1_v != 1) begin
            errors++;
            $display("FAIL line_wrap1: got cyc=%0d V=%0d, expected cyc=1600 V=1", wrap1, wrap1_v);
        end
        checks++;
        if (wrap2 != 3200 || wrap2_v != 2) begin
            errors++;
            $display("FAIL line_wrap2: got cyc=%0d V=%0d, expected cyc=3200 V=2", wrap2, wrap2_v);
        end
        checks++;
        if (hs_fall_h != 656 + LAG || hs_fall_cyc != 2 * (656 + LAG)) begin
            errors++;
            $display("FAIL hsync_fall: got H=%0d cyc=%0d, expected H=%0d cyc=%0d",
                     hs_fall_h, hs_fall_cyc, 656 + LAG, 2 * (656 + LAG));
        end
        checks++;
        if (hs_low != 192) begin
            errors++;
            $display("FAIL hsync_width: got %0d clks, expected 192", hs_low);
        end
        checks++;
        if (vo_fall_h != 640 + LAG) begin
            errors++;
            $display("FAIL video_fall: got H=%0d, expected %0d", vo_fall_h, 640 + LAG);
        end
        checks++;
        if (vo_rise_h != LAG) begin
            errors++;
            $display("FAIL video_rise: got H=%0d, expected %0d", vo_rise_h, LAG);
        end
    endtask

    // One full frame of instance B (15x10 pixels, 3 clks each = 450 clks).
    task automatic test_frame();
        int f1 = -1, f2 = -1, f1_pos = -1, f1_prev = -1;
        int fs_cnt = 0, vs_low = 0, vs_fall_v = -1, vo_ticks = 0, vo_bad = 0;
        int budget = 0;
        logic [9:0] ph = if_b.HCount, pv = if_b.VCount, hp = if_b.HCount, vp = if_b.VCount;
        logic pvs = if_b.vsync;
        logic [9:0] rh, rv;
        while (f2 < 0 && budget < 1200) begin
            step();
            budget++;
            if (if_b.pixel_tick) begin hp = ph; vp = pv; end
            if (if_b.frame_start) begin
                if (f1 < 0) begin
                    f1      = cyc;
                    f1_pos  = int'({if_b.HCount, if_b.VCount});
                    f1_prev = int'({ph, pv});
                end else begin
                    f2 = cyc;
                end
            end
            if (f1 >= 0 && f2 < 0) begin
                if (if_b.frame_start) fs_cnt++;
                if (!if_b.vsync) vs_low++;
                if (pvs && !if_b.vsync && vs_fall_v < 0) vs_fall_v = int'(if_b.VCount);
                if (if_b.pixel_tick && if_b.video_on) vo_ticks++;
                rh = (LAG != 0) ? hp : if_b.HCount;
                rv = (LAG != 0) ? vp : if_b.VCount;
                if (if_b.video_on !== 1'(rh < 10'd8 && rv < 10'd6)) vo_bad++;
            end
            ph  = if_b.HCount;
            pv  = if_b.VCount;
            pvs = if_b.vsync;
        end
        checks++;
        if (f1 < 0 || (f1 % 450) != 0 || f1_pos != 0 || f1_prev != ((14 << 10) | 9)) begin
            errors++;
            $display("FAIL frame_start_pos: got cyc=%0d pos=%0h prev=%0h, expected cyc%%450=0 pos=0 prev=%0h",
                     f1, f1_pos, f1_prev, (14 << 10) | 9);
        end
        checks++;
        if (f2 - f1 != 450 || fs_cnt != 1) begin
            errors++;
            $display("FAIL frame_period: got spacing=%0d pulses=%0d, expected 450 1", f2 - f1, fs_cnt);
        end
        checks++;
        if (vs_low != 90 || vs_fall_v != 7) begin
            errors++;
            $display("FAIL vsync_width: got %0d clks fall_V=%0d, expected 90 7", vs_low, vs_fall_v);
        end
        checks++;
        if (vo_ticks != 48) begin
            errors++;
            $display("FAIL video_ticks: got %0d, expected 48", vo_ticks);
        end
        checks++;
        if (vo_bad != 0) begin
            errors++;
            $display("FAIL video_decode: %0d bad cycles, expected 0", vo_bad);
        end
    endtask

    // Mid-line reset on A, then mid-frame reset on B, then normal scan.
    task automatic test_mid_reset();
        int budget = 0, fs_cyc = -1;
        while (if_a.HCount != 10'd700 && budget < 2000) begin step(); budget++; end
        rst_n = 1'b0;
        step();
        checks++;
        if ({if_a.HCount, if_a.VCount, if_a.hsync} !== {10'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_a: got H=%0d V=%0d hs=%b, expected 0 0 1",
                     if_a.HCount, if_a.VCount, if_a.hsync);
        end
        rst_n = 1'b1;
        budget = 0;
        while (!(if_b.HCount == 10'd10 && if_b.VCount == 10'd4) && budget < 1000) begin
            step();
            budget++;
        end
        checks++;
        if (if_b.HCount !== 10'd10 || if_b.VCount !== 10'd4) begin
            errors++;
            $display("FAIL mid_reset_reach: got H=%0d V=%0d, expected 10 4", if_b.HCount, if_b.VCount);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({if_b.HCount, if_b.VCount, if_b.hsync, if_b.vsync, if_b.video_on,
             if_b.pixel_tick, if_b.frame_start} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_b: got H=%0d V=%0d hs=%b vs=%b vo=%b tick=%b fs=%b, expected 0 0 1 1 0 0 0",
                     if_b.HCount, if_b.VCount, if_b.hsync, if_b.vsync,
                     if_b.video_on, if_b.pixel_tick, if_b.frame_start);
        end
        rst_n = 1'b1;
        step();
        step();
        step();
        checks++;
        if ({if_b.HCount, if_b.VCount, if_b.pixel_tick} !== {10'd1, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_resume: got H=%0d V=%0d tick=%b, expected 1 0 1",
                     if_b.HCount, if_b.VCount, if_b.pixel_tick);
        end
        while (cyc < 460) begin
            step();
            if (if_b.frame_start && fs_cyc < 0) fs_cyc = cyc;
        end
        checks++;
        if (fs_cyc != 450) begin
            errors++;
            $display("FAIL mid_reset_frame: got frame_start at cyc=%0d, expected 450", fs_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_line();
        test_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
